ts_bit_packer_10to32: RTL and testbench

//   Gearbox stage feeding the 32-bit recorder storage. Packs a continuous stream of
//   IN_W-bit words, MSB-first, into OUT_W-bit words, with no gaps between input words.

---
 rtl/ts_bit_packer_10to32.sv | 153 +++++++++++++++
 tb/tb_ts_bit_packer_10to32.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_bit_packer_10to32.sv
// ts_bit_packer_10to32
// Gearbox stage in front of the 32-bit recorder storage. Packs a gap-free stream of
// IN_W-bit words MSB-first into OUT_W-bit words and hands them off over valid/ready.
// A flush closes the stream by emitting the leftover bits as a zero-padded word
// tagged with its valid-bit count.
module ts_bit_packer_10to32 #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_in,
    input  logic [IN_W-1:0]  data_in,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [5:0]       out_bits,
    output logic             out_last,
    output logic             flush_done,
    output logic             overrun,
    output logic [CNT_W-1:0] word_count
);

    localparam int WIDE_W    = OUT_W + IN_W;
    localparam int REM_SHIFT = OUT_W - IN_W;

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_FLUSH_PEND = 1'b1
    } state_t;

    state_t             state_r;
    logic [OUT_W-1:0]   acc_r;
    logic [5:0]         fill_r;
    logic               out_valid_r;
    logic [OUT_W-1:0]   out_data_r;
    logic [5:0]         out_bits_r;
    logic               out_last_r;
    logic               flush_done_r;
    logic               overrun_r;
    logic [CNT_W-1:0]   word_count_r;

    logic               free_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               handoff_s;
    logic [6:0]         shift_s;
    logic [6:0]         sum_s;
    logic [WIDE_W-1:0]  wide_s;
    logic               word_done_s;
    logic [OUT_W-1:0]   acc_next_s;
    logic [5:0]         fill_next_s;

    // Handshake qualifiers: the output register can take a new word when it is empty
    // or being drained this cycle; input is only taken while running.
    always_comb begin
        free_s     = !out_valid_r || out_ready;
        in_ready_s = (state_r == ST_RUN) && free_s;
        accept_s   = write_in && in_ready_s;
        handoff_s  = out_valid_r && out_ready;
    end

    // Append the incoming word just below the filled bits and split off a full word
    // when the accumulator overflows; the remainder is re-left-justified.
    always_comb begin
        shift_s     = 7'(OUT_W) - {1'b0, fill_r};
        wide_s      = {acc_r, {IN_W{1'b0}}} | ({{OUT_W{1'b0}}, data_in} << shift_s);
        sum_s       = {1'b0, fill_r} + 7'(IN_W);
        word_done_s = (sum_s >= 7'(OUT_W));
        if (word_done_s) begin
            acc_next_s  = OUT_W'(wide_s[IN_W-1:0]) << REM_SHIFT;
            fill_next_s = 6'(sum_s - 7'(OUT_W));
        end else begin
            acc_next_s  = wide_s[WIDE_W-1:IN_W];
            fill_next_s = sum_s[5:0];
        end
    end

    // Packer state, output register, flush sequencing and status counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_RUN;
            acc_r        <= {OUT_W{1'b0}};
            fill_r       <= 6'd0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {OUT_W{1'b0}};
            out_bits_r   <= 6'd0;
            out_last_r   <= 1'b0;
            flush_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            word_count_r <= {CNT_W{1'b0}};
        end else begin
            flush_done_r <= 1'b0;

            if (handoff_s) begin
                out_valid_r  <= 1'b0;
                word_count_r <= word_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (write_in && !in_ready_s) begin
                overrun_r <= 1'b1;
            end

            case (state_r)
                ST_RUN: begin
                    if (accept_s) begin
                        acc_r  <= acc_next_s;
                        fill_r <= fill_next_s;
                        if (word_done_s) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= wide_s[WIDE_W-1:IN_W];
                            out_bits_r  <= 6'(OUT_W);
                            out_last_r  <= 1'b0;
                        end
                    end
                    if (flush) begin
                        state_r <= ST_FLUSH_PEND;
                    end
                end
                ST_FLUSH_PEND: begin
                    if (free_s) begin
                        if (fill_r != 6'd0) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= acc_r;
                            out_bits_r  <= fill_r;
                            out_last_r  <= 1'b1;
                            acc_r       <= {OUT_W{1'b0}};
                            fill_r      <= 6'd0;
                        end
                        flush_done_r <= 1'b1;
                        state_r      <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_bits   = out_bits_r;
    assign out_last   = out_last_r;
    assign flush_done = flush_done_r;
    assign overrun    = overrun_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_ts_bit_packer_10to32.sv
// Bench for ts_bit_packer_10to32: directed scenario tasks plus a randomized run,
// with a bit-queue reference model that predicts every handed-off word.
module tb_ts_bit_packer_10to32;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_in;
    logic [9:0]  data_in;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_last;
    logic        flush_done;
    logic        overrun;
    logic [15:0] word_count;

    int vectors = 0;
    int miscompares = 0;

    ts_bit_packer_10to32 dut (
        .clock      (clock),
        .reset      (reset),
        .write_in   (write_in),
        .data_in    (data_in),
        .flush      (flush),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bits   (out_bits),
        .out_last   (out_last),
        .flush_done (flush_done),
        .overrun    (overrun),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    // Reference model: the stream as a queue of bits, and the words it must produce.
    typedef struct {
        logic [31:0] d;
        logic [5:0]  n;
        logic        l;
    } word_t;

    bit          bitq[$];
    word_t       expq[$];
    bit          pend = 1'b0;
    bit          ovr_exp = 1'b0;
    logic [15:0] cnt_exp = 16'd0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [5:0]  prev_n;
    logic        prev_l;

    // Cycle monitor: compares every handoff and the status outputs against the model.
    always @(negedge clock) begin
        if (reset) begin
            bitq.delete();
            expq.delete();
            pend       = 1'b0;
            ovr_exp    = 1'b0;
            cnt_exp    = 16'd0;
            prev_stall = 1'b0;
        end else begin
            if (flush_done) begin
                vectors++;
                if (!pend) begin
                    miscompares++;
                    $display("FAIL flush_done_unexpected: got 1, required 0");
                end
                if (bitq.size() > 0) begin
                    word_t w;
                    w.d = 32'd0;
                    w.n = 6'(bitq.size());
                    w.l = 1'b1;
                    for (int i = 0; i < bitq.size(); i++) w.d[31-i] = bitq[i];
                    expq.push_back(w);
                    bitq.delete();
                end
                pend = 1'b0;
            end

            vectors++;
            if (in_ready !== (!pend && (!out_valid || out_ready))) begin
                miscompares++;
                $display("FAIL in_ready: got %b, required %b", in_ready, (!pend && (!out_valid || out_ready)));
            end

            vectors++;
            if (overrun !== ovr_exp) begin
                miscompares++;
                $display("FAIL overrun: got %b, required %b", overrun, ovr_exp);
            end

            vectors++;
            if (word_count !== cnt_exp) begin
                miscompares++;
                $display("FAIL word_count: got %0d, required %0d", word_count, cnt_exp);
            end

            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_bits !== prev_n || out_last !== prev_l) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b %h/%0d/%b, required v=1 %h/%0d/%b",
                             out_valid, out_data, out_bits, out_last, prev_d, prev_n, prev_l);
                end
            end

            if (out_valid && out_ready) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL handoff_extra: got %h/%0d/%b, required no word", out_data, out_bits, out_last);
                end else begin
                    word_t e;
                    e = expq.pop_front();
                    if (out_data !== e.d || out_bits !== e.n || out_last !== e.l) begin
                        miscompares++;
                        $display("FAIL handoff_word: got %h/%0d/%b, required %h/%0d/%b",
                                 out_data, out_bits, out_last, e.d, e.n, e.l);
                    end
                end
                cnt_exp = cnt_exp + 16'd1;
            end

            if (write_in && !in_ready) ovr_exp = 1'b1;
            if (write_in && in_ready) begin
                for (int i = 9; i >= 0; i--) bitq.push_back(data_in[i]);
                if (bitq.size() >= 32) begin
                    word_t w;
                    w.n = 6'd32;
                    w.l = 1'b0;
                    for (int i = 0; i < 32; i++) w.d[31-i] = bitq.pop_front();
                    expq.push_back(w);
                end
            end
            if (flush && !pend) pend = 1'b1;

            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_n = out_bits;
            prev_l = out_last;
        end
    end

    task automatic tick(input logic we, input logic [9:0] d, input logic fl, input logic ordy);
        write_in  = we;
        data_in   = d;
        flush     = fl;
        out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 10'd0, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || word_count !== 16'd0 || overrun !== 1'b0 ||
            flush_done !== 1'b0 || out_data !== 32'd0 || out_bits !== 6'd0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b v=%b cnt=%0d ovr=%b fd=%b d=%h n=%0d l=%b, required rdy=1 rest 0",
                     in_ready, out_valid, word_count, overrun, flush_done, out_data, out_bits, out_last);
        end
        reset = 1'b0;
    endtask

    task automatic test_packing();
        tick(1'b1, 10'h3FF, 1'b0, 1'b1);
        tick(1'b1, 10'h000, 1'b0, 1'b1);
        tick(1'b1, 10'h3FF, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pack_early_valid: got %b, required 0", out_valid);
        end
        tick(1'b1, 10'h3FF, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFC00FFF || out_bits !== 6'd32 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL pack_word: got v=%b %h/%0d/%b, required v=1 ffc00fff/32/0",
                     out_valid, out_data, out_bits, out_last);
        end
    endtask

    task automatic test_flush();
        tick(1'b0, 10'd0, 1'b1, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || flush_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_pending: got v=%b fd=%b, required v=0 fd=0", out_valid, flush_done);
        end
        tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hFF000000 || out_bits !== 6'd8 || out_last !== 1'b1 || flush_done !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_partial: got v=%b %h/%0d/%b fd=%b, required v=1 ff000000/8/1 fd=1",
                     out_valid, out_data, out_bits, out_last, flush_done);
        end
        tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (word_count !== 16'd2 || out_valid !== 1'b0 || flush_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after: got cnt=%0d v=%b fd=%b, required cnt=2 v=0 fd=0", word_count, out_valid, flush_done);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] base;
        base = word_count;
        for (int i = 0; i < 16; i++) tick(1'b1, 10'h200, 1'b0, 1'b1);
        tick(1'b0, 10'd0, 1'b0, 1'b1);
        tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (word_count - base !== 16'd5) begin
            miscompares++;
            $display("FAIL boundary_words: got %0d, required 5", word_count - base);
        end
        tick(1'b0, 10'd0, 1'b1, 1'b1);
        vectors++;
        if (flush_done !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_fd_early: got %b, required 0", flush_done);
        end
        tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (flush_done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_empty_flush: got fd=%b v=%b, required fd=1 v=0", flush_done, out_valid);
        end
        tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (word_count - base !== 16'd5) begin
            miscompares++;
            $display("FAIL boundary_no_extra: got %0d, required 5", word_count - base);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] saved;
        logic [15:0] base;
        base = word_count;
        for (int i = 0; i < 4; i++) tick(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall: got v=%b rdy=%b ovr=%b, required v=1 rdy=0 ovr=0", out_valid, in_ready, overrun);
        end
        saved = out_data;
        tick(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_overrun: got %b, required 1", overrun);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== saved) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b %h, required v=1 %h", out_valid, out_data, saved);
        end
        tick(1'b0, 10'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (word_count - base !== 16'd2) begin
            miscompares++;
            $display("FAIL bp_count: got %0d, required 2", word_count - base);
        end
    endtask

    task automatic test_flush_with_write();
        logic [9:0] d1, d2, d3, d4;
        d1 = 10'($urandom_range(0, 1023));
        d2 = 10'($urandom_range(0, 1023));
        d3 = 10'($urandom_range(0, 1023));
        d4 = 10'($urandom_range(0, 1023));
        tick(1'b1, d1, 1'b0, 1'b1);
        tick(1'b1, d2, 1'b0, 1'b1);
        tick(1'b1, d3, 1'b0, 1'b1);
        tick(1'b1, d4, 1'b1, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== {d1, d2, d3, d4[9:8]} || out_bits !== 6'd32 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fw_full: got v=%b %h/%0d/%b rdy=%b, required v=1 %h/32/0 rdy=0",
                     out_valid, out_data, out_bits, out_last, in_ready, {d1, d2, d3, d4[9:8]});
        end
        tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== {d4[7:0], 24'h000000} || out_bits !== 6'd8 || out_last !== 1'b1 || flush_done !== 1'b1) begin
            miscompares++;
            $display("FAIL fw_partial: got v=%b %h/%0d/%b fd=%b, required v=1 %h/8/1 fd=1",
                     out_valid, out_data, out_bits, out_last, flush_done, {d4[7:0], 24'h000000});
        end
        tick(1'b0, 10'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_in_flush();
        for (int i = 0; i < 3; i++) tick(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b1);
        tick(1'b1, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
        tick(1'b0, 10'd0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || flush_done !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rf_pending: got v=%b fd=%b rdy=%b, required v=1 fd=0 rdy=0", out_valid, flush_done, in_ready);
        end
        reset = 1'b1;
        tick(1'b0, 10'd0, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || word_count !== 16'd0 || overrun !== 1'b0 ||
            flush_done !== 1'b0 || out_data !== 32'd0 || out_bits !== 6'd0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL rf_reset_values: got rdy=%b v=%b cnt=%0d ovr=%b fd=%b d=%h n=%0d l=%b, required rdy=1 rest 0",
                     in_ready, out_valid, word_count, overrun, flush_done, out_data, out_bits, out_last);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 10'd0, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || word_count !== 16'd0 || flush_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rf_nothing_emitted: got v=%b cnt=%0d fd=%b, required v=0 cnt=0 fd=0", out_valid, word_count, flush_done);
        end
    endtask

    task automatic test_random();
        int guard;
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
        end
        tick(1'b0, 10'd0, 1'b1, 1'b1);
        guard = 0;
        while ((pend || expq.size() != 0 || out_valid) && guard < 50) begin
            tick(1'b0, 10'd0, 1'b0, 1'b1);
            guard++;
        end
        vectors++;
        if (guard >= 50 || expq.size() != 0) begin
            miscompares++;
            $display("FAIL random_drain: got %0d words outstanding after %0d cycles, required 0", expq.size(), guard);
        end
    endtask

    initial begin
        reset     = 1'b1;
        write_in  = 1'b0;
        data_in   = 10'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_packing();
        test_flush();
        test_boundary();
        test_backpressure();
        test_flush_with_write();
        test_reset_in_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
